// File: rtl/screen_ram_writer.sv
// Write side of the packed 4-bit-per-pixel screen RAM: single-pixel read-modify-write
// and whole-screen clear, sharing the RAM's second port with the display path.
module screen_ram_writer #(
    parameter int SCREEN_WIDTH = 11,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int WIDTH        = 488,
    parameter int HEIGHT       = 280,
    parameter int WORDS        = WIDTH * HEIGHT / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SCREEN_WIDTH-1:0] req_x,
    input  logic [SCREEN_WIDTH-1:0] req_y,
    input  logic [3:0]              req_color,
    input  logic                    clr_start,
    input  logic [3:0]              clr_color,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_re,
    input  logic [DATA_WIDTH-1:0]   ram_rdata,
    output logic                    ram_we,
    output logic [DATA_WIDTH-1:0]   ram_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        CLR  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              nibble_q;
    logic [3:0]              color_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    err_q;

    logic                    out_of_range;
    logic                    accept;
    logic                    drop;
    logic                    clr_enter;
    logic                    clr_last;
    logic [ADDR_WIDTH+2:0]   pix_index;
    logic [4:0]              shamt;
    logic [DATA_WIDTH-1:0]   nib_mask;
    logic [DATA_WIDTH-1:0]   nib_data;

    // Low 3 bits of the pixel index equal req_x[2:0] because WIDTH is a multiple of 8.
    assign pix_index    = (ADDR_WIDTH+3)'(32'(req_y) * 32'(WIDTH) + 32'(req_x));
    assign out_of_range = (req_x >= SCREEN_WIDTH'(WIDTH)) || (req_y >= SCREEN_WIDTH'(HEIGHT));
    assign clr_last     = (clr_cnt_q == ADDR_WIDTH'(WORDS - 1));

    assign shamt    = {nibble_q, 2'b00};
    assign nib_mask = DATA_WIDTH'(4'hF) << shamt;
    assign nib_data = DATA_WIDTH'(color_q) << shamt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            nibble_q  <= '0;
            color_q   <= '0;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= drop;
            if (clr_enter) begin
                color_q   <= clr_color;
                clr_cnt_q <= '0;
            end else if (accept) begin
                addr_q   <= pix_index[ADDR_WIDTH+2:3];
                nibble_q <= pix_index[2:0];
                color_q  <= req_color;
            end else if (state_q == CLR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    // Next state and handshake decisions; clear takes priority over a pending request.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        drop      = 1'b0;
        clr_enter = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    clr_enter = 1'b1;
                    state_d   = CLR;
                end else if (req_valid) begin
                    if (out_of_range) begin
                        drop = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = WR;
            WR:      state_d = IDLE;
            CLR:     if (clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst && (state_q == IDLE) && !clr_start;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        err       = err_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            RD: begin
                ram_re   = 1'b1;
                ram_addr = addr_q;
            end
            WR: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = (ram_rdata & ~nib_mask) | nib_data;
                done      = 1'b1;
            end
            CLR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = {(DATA_WIDTH/4){color_q}};
                done      = clr_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_screen_ram_writer.sv
// Directed bench for screen_ram_writer: pixel read-modify-write, range errors,
// full-screen clear with latched colour, and reset abort mid-clear.
module tb_screen_ram_writer;

    localparam int WORDS = 17080;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_x;
    logic [10:0] req_y;
    logic [3:0]  req_color;
    logic        clr_start;
    logic [3:0]  clr_color;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] ram_addr;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic        ram_we;
    logic [31:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    screen_ram_writer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic pixel_write(input logic [10:0] x, input logic [10:0] y, input logic [3:0] c,
                               input logic [31:0] rdata, input logic [15:0] exp_addr,
                               input logic [31:0] exp_wdata);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_color = c;
        #1;
        check("px_ready_before", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        ram_rdata = rdata;
        #1;
        check("px_rd_re", 32'(ram_re), 32'd1);
        check("px_rd_we", 32'(ram_we), 32'd0);
        check("px_rd_addr", 32'(ram_addr), 32'(exp_addr));
        check("px_rd_ready", 32'(req_ready), 32'd0);
        check("px_rd_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("px_wr_we", 32'(ram_we), 32'd1);
        check("px_wr_re", 32'(ram_re), 32'd0);
        check("px_wr_addr", 32'(ram_addr), 32'(exp_addr));
        check("px_wr_data", ram_wdata, exp_wdata);
        check("px_wr_done", 32'(done), 32'd1);
        @(negedge clk);
        #1;
        check("px_idle_ready", 32'(req_ready), 32'd1);
        check("px_idle_done", 32'(done), 32'd0);
        check("px_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic bad_request(input logic [10:0] x, input logic [10:0] y);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_color = 4'h7;
        #1;
        check("bad_ready", 32'(req_ready), 32'd1);
        check("bad_err_early", 32'(err), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("bad_err", 32'(err), 32'd1);
        check("bad_re", 32'(ram_re), 32'd0);
        check("bad_we", 32'(ram_we), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("bad_err_clear", 32'(err), 32'd0);
        check("bad_re2", 32'(ram_re), 32'd0);
    endtask

    initial begin
        int bad_cycles;
        int done_cycles;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        clr_start = 1'b0;
        clr_color = '0;
        ram_rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", {26'd0, req_ready, busy, done, err, ram_re, ram_we}, 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", ram_wdata, 32'd0);
        req_valid = 1'b1;
        #1;
        check("rst_ready_held", 32'(req_ready), 32'd0);
        req_valid = 1'b0;

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        pixel_write(11'd0, 11'd0, 4'h5, 32'hFFFF_FFFF, 16'd0, 32'hFFFF_FFF5);
        pixel_write(11'd13, 11'd2, 4'hA, 32'h0000_0000, 16'd123, 32'h00A0_0000);
        pixel_write(11'd487, 11'd279, 4'hC, 32'h1234_5678, 16'd17079, 32'hC234_5678);

        bad_request(11'd488, 11'd0);
        bad_request(11'd0, 11'd280);

        // Clear collides with a pending request; the request must wait.
        req_valid = 1'b1;
        req_x     = 11'd1;
        req_y     = 11'd1;
        req_color = 4'h9;
        clr_start = 1'b1;
        clr_color = 4'h3;
        #1;
        check("clr_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        clr_start   = 1'b0;
        clr_color   = 4'hE;
        bad_cycles  = 0;
        done_cycles = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (i == 50) begin
                clr_start = 1'b1;
                clr_color = 4'h7;
            end else begin
                clr_start = 1'b0;
            end
            #1;
            if (!(ram_we === 1'b1 && ram_re === 1'b0 && ram_addr === 16'(i) &&
                  ram_wdata === 32'h3333_3333 && req_ready === 1'b0 && busy === 1'b1))
                bad_cycles++;
            if (done === 1'b1) done_cycles++;
            if (i == 0) check("clr_first_addr", 32'(ram_addr), 32'd0);
            if (i == WORDS - 1) begin
                check("clr_last_addr", 32'(ram_addr), 32'd17079);
                check("clr_last_done", 32'(done), 32'd1);
            end
            @(negedge clk);
        end
        check("clr_bad_cycles", 32'(bad_cycles), 32'd0);
        check("clr_done_count", 32'(done_cycles), 32'd1);
        pixel_write(11'd1, 11'd1, 4'h9, 32'h3333_3333, 16'd61, 32'h3333_3393);

        // Reset mid-clear aborts writes at once.
        clr_start = 1'b1;
        clr_color = 4'h6;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("abort_addr", 32'(ram_addr), 32'd100);
        check("abort_we_before", 32'(ram_we), 32'd1);
        check("abort_data", ram_wdata, 32'h6666_6666);
        rst = 1'b0;
        #1;
        check("abort_we_now", 32'(ram_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr_zero", 32'(ram_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (ram_we !== 1'b0 || ram_re !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
                bad_cycles++;
        end
        check("post_abort_idle", 32'(bad_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
